// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
//   lsu_state_e : wait-state FSM states
//   lsu_dec_e   : address decode result
//   TOHOST_OFS / CYCLE_OFS : MMIO word offsets from MMIO_BASE
//   lane_mask() : expands a 4-bit byte enable into a 32-bit bit mask
package lsu_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StBusy = 2'd1,
      StResp = 2'd2
   } lsu_state_e;

   typedef enum logic [1:0] {
      DecRam  = 2'd0,
      DecMmio = 2'd1,
      DecBad  = 2'd2
   } lsu_dec_e;

   localparam logic [31:0] TOHOST_OFS = 32'h0000_0000;
   localparam logic [31:0] CYCLE_OFS  = 32'h0000_0004;

   function automatic logic [31:0] lane_mask(input logic [3:0] be);
      lane_mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
   endfunction

endpackage

// File: rtl/u_dmem_sram.sv
// Single-port synchronous data SRAM, DEPTH_W x 32, byte write enables.
//   clk_i  : clock
//   en_i   : access enable (read always happens, writes gated by we_i)
//   we_i   : byte write enables, lane i = bits[8i+7:8i]
//   addr_i : word address
//   wd_i   : write data
//   rd_o   : registered read data, returns the pre-write contents
module u_dmem_sram #(
   parameter int unsigned DEPTH_W = 1024,
   localparam int unsigned AW     = $clog2(DEPTH_W)
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wd_i,
   output logic [31:0]   rd_o
);

   logic [31:0] mem_q [DEPTH_W];
   logic [31:0] rd_q;

   always_ff @(posedge clk_i) begin
      if (en_i) begin
         rd_q <= mem_q[addr_i];
         for (int i = 0; i < 4; i++) begin
            if (we_i[i]) begin
               mem_q[addr_i][8*i +: 8] <= wd_i[8*i +: 8];
            end
         end
      end
   end

   assign rd_o = rd_q;

endmodule

// File: rtl/u_lsu.sv
// Data-memory responder for the execute stage's load/store port.
// Serves word accesses to a local byte-enabled SRAM and two MMIO words
// (tohost write register, free-running cycle counter). Load data is returned
// one cycle after the access; WAIT > 0 inserts stall cycles first.
//   clk_i, rst_ni   : clock, async active-low reset
//   lsu_a_i         : byte address
//   lsu_we_i        : byte write enables (nonzero = store)
//   lsu_wd_i        : store data
//   lsu_re_i        : byte read enables (nonzero = load)
//   lsu_vld_o       : response pulse (loads and stores)
//   lsu_rd_o        : load data, holds when lsu_vld_o = 0
//   lsu_stall_o     : hold the execute stage while high
//   lsu_err_o       : misaligned or unmapped access pulse
//   tohost_vld_o    : pulse when a tohost store completes
//   tohost_dat_o    : last value stored to tohost
module u_lsu
   import lsu_pkg::*;
#(
   parameter int unsigned DEPTH_W   = 1024,
   parameter logic [31:0] RAM_BASE  = 32'h0000_0000,
   parameter logic [31:0] MMIO_BASE = 32'h8000_0000,
   parameter int unsigned WAIT      = 0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] lsu_a_i,
   input  logic [3:0]  lsu_we_i,
   input  logic [31:0] lsu_wd_i,
   input  logic [3:0]  lsu_re_i,
   output logic        lsu_vld_o,
   output logic [31:0] lsu_rd_o,
   output logic        lsu_stall_o,
   output logic        lsu_err_o,
   output logic        tohost_vld_o,
   output logic [31:0] tohost_dat_o
);

   localparam int unsigned AW      = $clog2(DEPTH_W);
   localparam logic [3:0]  CntInit = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

   lsu_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] cycle_q, cyc_hold_q, cyc_snap;
   logic        vld_q, err_q, thv_q, load_q, src_ram_q;
   logic [3:0]  mask_q;
   logic [31:0] mmio_rd_q, tohost_dat_q, last_rd_q;
   logic [31:0] sram_rd, resp_data;

   logic        req, is_load, is_store, bad, go, first;
   logic        hit_tohost, hit_cycle;
   lsu_dec_e    dec;

   // Gating with reset keeps stall low and blocks any SRAM write during reset.
   assign is_load  = (lsu_re_i != 4'h0);
   assign is_store = (lsu_we_i != 4'h0);
   assign req      = rst_ni & (is_load | is_store);

   assign hit_tohost = (lsu_a_i == MMIO_BASE + TOHOST_OFS);
   assign hit_cycle  = (lsu_a_i == MMIO_BASE + CYCLE_OFS);

   always_comb begin
      dec = DecBad;
      if (lsu_a_i[31:AW+2] == RAM_BASE[31:AW+2]) begin
         dec = DecRam;
      end else if (hit_tohost || hit_cycle) begin
         dec = DecMmio;
      end
   end

   assign bad = (lsu_a_i[1:0] != 2'b00) | (dec == DecBad);

   // go: cycle whose closing edge performs the access.
   // first: request seen for the first time (cycle counter sample point).
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      lsu_stall_o = 1'b0;
      go          = 1'b0;
      first       = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (req) begin
               first = 1'b1;
               if (WAIT == 0) begin
                  go = 1'b1;
               end else begin
                  state_d     = StBusy;
                  cnt_d       = CntInit;
                  lsu_stall_o = 1'b1;
               end
            end
         end
         StBusy: begin
            lsu_stall_o = 1'b1;
            if (cnt_q == 4'd0) begin
               go      = 1'b1;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StResp: begin
            if (req) begin
               first   = 1'b1;
               state_d = StBusy;
               cnt_d   = CntInit;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign cyc_snap = first ? cycle_q : cyc_hold_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         cnt_q        <= 4'd0;
         cycle_q      <= 32'd0;
         cyc_hold_q   <= 32'd0;
         vld_q        <= 1'b0;
         err_q        <= 1'b0;
         thv_q        <= 1'b0;
         load_q       <= 1'b0;
         src_ram_q    <= 1'b0;
         mask_q       <= 4'h0;
         mmio_rd_q    <= 32'd0;
         tohost_dat_q <= 32'd0;
         last_rd_q    <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         cycle_q    <= cycle_q + 32'd1;
         cyc_hold_q <= cyc_snap;
         last_rd_q  <= lsu_rd_o;
         vld_q      <= go;
         err_q      <= go & bad;
         thv_q      <= go & ~bad & is_store & hit_tohost;
         if (go) begin
            load_q    <= is_load;
            mask_q    <= lsu_re_i;
            src_ram_q <= (dec == DecRam);
            // Capture pre-store tohost value so read+write returns old data.
            mmio_rd_q <= hit_tohost ? tohost_dat_q : cyc_snap;
            if (~bad && is_store && hit_tohost) begin
               tohost_dat_q <= (tohost_dat_q & ~lane_mask(lsu_we_i))
                             | (lsu_wd_i & lane_mask(lsu_we_i));
            end
         end
      end
   end

   u_dmem_sram #(
      .DEPTH_W (DEPTH_W)
   ) u_sram (
      .clk_i  (clk_i),
      .en_i   (go & ~bad & (dec == DecRam)),
      .we_i   (lsu_we_i),
      .addr_i (lsu_a_i[AW+1:2]),
      .wd_i   (lsu_wd_i),
      .rd_o   (sram_rd)
   );

   // Stores leave lsu_rd untouched; errors force it to zero.
   always_comb begin
      resp_data = src_ram_q ? sram_rd : mmio_rd_q;
      lsu_rd_o  = last_rd_q;
      if (vld_q && err_q) begin
         lsu_rd_o = 32'd0;
      end else if (vld_q && load_q) begin
         lsu_rd_o = resp_data & lane_mask(mask_q);
      end
   end

   assign lsu_vld_o    = vld_q;
   assign lsu_err_o    = err_q;
   assign tohost_vld_o = thv_q;
   assign tohost_dat_o = tohost_dat_q;

endmodule

// File: tb/tb_u_lsu.sv
module tb_u_lsu;

   typedef struct packed {
      logic [31:0] a;
      logic [3:0]  we;
      logic [31:0] wd;
      logic [3:0]  re;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic        exp_thv;
      logic [31:0] exp_thd;
   } vec_t;

   typedef struct {
      logic [31:0] rd;
      logic        err;
      logic        thv;
      logic [31:0] thd;
      int          idx;
   } exp_t;

   logic clk;
   int   checks = 0;
   int   errors = 0;

   // DUT with no wait states
   logic        rst0;
   logic [31:0] a0, wd0, rd0, thd0;
   logic [3:0]  we0, re0;
   logic        vld0, stall0, err0, thv0;

   // DUT with WAIT = 2
   logic        rst2;
   logic [31:0] a2, wd2, rd2, thd2;
   logic [3:0]  we2, re2;
   logic        vld2, stall2, err2, thv2;

   exp_t sb_q[$];
   bit   sb_on = 1'b0;
   vec_t vecs[18];

   u_lsu #(.WAIT(0)) dut0 (
      .clk_i(clk), .rst_ni(rst0), .lsu_a_i(a0), .lsu_we_i(we0), .lsu_wd_i(wd0),
      .lsu_re_i(re0), .lsu_vld_o(vld0), .lsu_rd_o(rd0), .lsu_stall_o(stall0),
      .lsu_err_o(err0), .tohost_vld_o(thv0), .tohost_dat_o(thd0)
   );

   u_lsu #(.WAIT(2)) dut2 (
      .clk_i(clk), .rst_ni(rst2), .lsu_a_i(a2), .lsu_we_i(we2), .lsu_wd_i(wd2),
      .lsu_re_i(re2), .lsu_vld_o(vld2), .lsu_rd_o(rd2), .lsu_stall_o(stall2),
      .lsu_err_o(err2), .tohost_vld_o(thv2), .tohost_dat_o(thd2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Scoreboard monitor for dut0, sampled 2 time units after the rising edge.
   always @(posedge clk) begin
      #2;
      if (sb_on) begin
         chk("w0 stall", {31'd0, stall0}, 32'd0);
         if (vld0) begin
            if (sb_q.size() == 0) begin
               chk("unexpected vld", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk($sformatf("v%0d rd", e.idx), rd0, e.rd);
               chk($sformatf("v%0d err", e.idx), {31'd0, err0}, {31'd0, e.err});
               chk($sformatf("v%0d thv", e.idx), {31'd0, thv0}, {31'd0, e.thv});
               chk($sformatf("v%0d thd", e.idx), thd0, e.thd);
            end
         end
      end
   end

   // Drive one request into dut2 and wait for its response; lat = cycles to vld.
   task automatic do2(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd,
                      input logic [3:0] re, output logic [31:0] rd, output int lat);
      @(negedge clk);
      a2 = a; we2 = we; wd2 = wd; re2 = re;
      lat = -1;
      rd  = 32'd0;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #2;
         if (vld2) begin
            lat = k;
            rd  = rd2;
            break;
         end
      end
      @(negedge clk);
      we2 = 4'h0; re2 = 4'h0;
   endtask

   initial begin
      logic [31:0] c1, c2, r;
      int          lat;
      exp_t        e;

      vecs[0]  = '{32'h10, 4'hF, 32'hDEAD_BEEF, 4'h0, 32'h0000_0000, 1'b0, 1'b0, 32'h0};
      vecs[1]  = '{32'h10, 4'h0, 32'h0,         4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
      vecs[2]  = '{32'h20, 4'hF, 32'hFFFF_FFFF, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
      vecs[3]  = '{32'h20, 4'h5, 32'h1122_3344, 4'h0, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
      vecs[4]  = '{32'h20, 4'h0, 32'h0,         4'hF, 32'hFF22_FF44, 1'b0, 1'b0, 32'h0};
      vecs[5]  = '{32'h20, 4'h0, 32'h0,         4'h3, 32'h0000_FF44, 1'b0, 1'b0, 32'h0};
      vecs[6]  = '{32'h00, 4'hF, 32'hA5A5_A5A5, 4'h0, 32'h0000_FF44, 1'b0, 1'b0, 32'h0};
      vecs[7]  = '{32'h12, 4'h0, 32'h0,         4'hF, 32'h0000_0000, 1'b1, 1'b0, 32'h0};
      vecs[8]  = '{32'h4000_0000, 4'hF, 32'h1234_5678, 4'h0, 32'h0, 1'b1, 1'b0, 32'h0};
      vecs[9]  = '{32'h00, 4'h0, 32'h0,         4'hF, 32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0};
      vecs[10] = '{32'h10, 4'hF, 32'h0102_0304, 4'hF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0};
      vecs[11] = '{32'h10, 4'h0, 32'h0,         4'hF, 32'h0102_0304, 1'b0, 1'b0, 32'h0};
      vecs[12] = '{32'h8000_0000, 4'hF, 32'h1, 4'h0, 32'h0102_0304, 1'b0, 1'b1, 32'h1};
      vecs[13] = '{32'h8000_0000, 4'h0, 32'h0, 4'hF, 32'h0000_0001, 1'b0, 1'b0, 32'h1};
      vecs[14] = '{32'h8000_0004, 4'hF, 32'hFFFF_FFFF, 4'h0, 32'h1, 1'b0, 1'b0, 32'h1};
      vecs[15] = '{32'h8000_0008, 4'h0, 32'h0, 4'hF, 32'h0, 1'b1, 1'b0, 32'h1};
      vecs[16] = '{32'h8000_0000, 4'h2, 32'h0000_AB00, 4'h0, 32'h0, 1'b0, 1'b1, 32'h0000_AB01};
      vecs[17] = '{32'h8000_0000, 4'h0, 32'h0, 4'h2, 32'h0000_AB00, 1'b0, 1'b0, 32'h0000_AB01};

      rst0 = 1'b0; rst2 = 1'b0;
      a0 = '0; we0 = '0; wd0 = '0; re0 = '0;
      a2 = '0; we2 = '0; wd2 = '0; re2 = '0;
      repeat (3) @(negedge clk);

      chk("reset w0 outs", {26'd0, vld0, stall0, err0, thv0, |rd0, |thd0}, 32'd0);
      chk("reset w2 outs", {26'd0, vld2, stall2, err2, thv2, |rd2, |thd2}, 32'd0);

      rst0 = 1'b1; rst2 = 1'b1;
      @(negedge clk);

      // Table-driven back-to-back requests on the zero-wait unit
      sb_on = 1'b1;
      for (int i = 0; i < 18; i++) begin
         a0 = vecs[i].a; we0 = vecs[i].we; wd0 = vecs[i].wd; re0 = vecs[i].re;
         e.rd = vecs[i].exp_rd; e.err = vecs[i].exp_err;
         e.thv = vecs[i].exp_thv; e.thd = vecs[i].exp_thd; e.idx = i;
         sb_q.push_back(e);
         @(negedge clk);
      end
      we0 = 4'h0; re0 = 4'h0;
      repeat (3) @(negedge clk);
      sb_on = 1'b0;
      chk("sb drained", sb_q.size(), 32'd0);

      // Cycle counter: two loads whose requests are 3 cycles apart
      a0 = 32'h8000_0004; re0 = 4'hF;
      @(posedge clk); #2;
      chk("cyc1 vld", {31'd0, vld0}, 32'd1);
      c1 = rd0;
      @(negedge clk); re0 = 4'h0;
      @(negedge clk);
      @(negedge clk); re0 = 4'hF;
      @(posedge clk); #2;
      chk("cyc2 vld", {31'd0, vld0}, 32'd1);
      c2 = rd0;
      @(negedge clk); re0 = 4'h0;
      chk("cyc delta", c2 - c1, 32'd3);

      // WAIT=2: preload, then latency and back-to-back timing
      do2(32'h40, 4'hF, 32'h5555_AAAA, 4'h0, r, lat);
      chk("w2 store lat", lat, 32'd3);

      @(negedge clk);
      a2 = 32'h40; we2 = 4'h0; re2 = 4'hF;
      #1 chk("w2 stall T", {31'd0, stall2}, 32'd1);
      for (int k = 1; k <= 6; k++) begin
         if (k == 4) begin
            @(negedge clk);
            re2 = 4'b1100;
         end
         @(posedge clk); #2;
         if (k == 3 || k == 6) begin
            chk($sformatf("w2 vld T+%0d", k), {30'd0, vld2, stall2}, 32'd2);
            chk($sformatf("w2 rd T+%0d", k), rd2, (k == 3) ? 32'h5555_AAAA : 32'h5555_0000);
         end else begin
            chk($sformatf("w2 busy T+%0d", k), {30'd0, vld2, stall2}, 32'd1);
         end
      end
      @(negedge clk); re2 = 4'h0;
      @(negedge clk);

      // Reset while a store is in BUSY: dropped, outputs cleared
      a2 = 32'h40; we2 = 4'hF; wd2 = 32'hCAFE_F00D;
      @(posedge clk); #2;
      chk("w2 busy before rst", {31'd0, stall2}, 32'd1);
      rst2 = 1'b0;
      #1 chk("w2 rst outs", {26'd0, vld2, stall2, err2, thv2, |rd2, |thd2}, 32'd0);
      @(negedge clk); we2 = 4'h0; wd2 = 32'h0;
      @(negedge clk); rst2 = 1'b1;
      do2(32'h40, 4'h0, 32'h0, 4'hF, r, lat);
      chk("w2 post-rst lat", lat, 32'd3);
      chk("w2 post-rst rd", r, 32'h5555_AAAA);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
